// File: rtl/ap_ctrl_txn_driver.sv
// ap_ctrl_hs initiator: issues a programmed number of kernel starts separated by an idle
// gap, and measures start-to-done latency through a small in-order timestamp FIFO.
module ap_ctrl_txn_driver #(
  parameter int CNT_W       = 32,
  parameter int TXN_W       = 16,
  parameter int OUTST_DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cfg_start,
  input  logic [TXN_W-1:0] cfg_num_txn,
  input  logic [7:0]       cfg_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] txn_issued,
  output logic [TXN_W-1:0] txn_done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] total_cycles,
  output logic             proto_err
);
  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(OUTST_DEPTH);

  typedef enum logic [2:0] {
    st_idle,
    st_issue,
    st_gap,
    st_drain,
    st_fin
  } state_t;

  state_t           state_reg, state_next;
  logic [TXN_W-1:0] num_reg, num_next;
  logic [7:0]       gap_reg, gap_next;
  logic [7:0]       gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] cycle_reg, cycle_next;
  logic [TXN_W-1:0] txn_issued_reg, txn_issued_next;
  logic [TXN_W-1:0] txn_done_reg, txn_done_next;
  logic [CNT_W-1:0] last_lat_reg, last_lat_next;
  logic [CNT_W-1:0] max_lat_reg, max_lat_next;
  logic [CNT_W-1:0] total_reg, total_next;
  logic             perr_reg, perr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   occ_reg, occ_next;

  logic [CNT_W-1:0] ts_mem [OUTST_DEPTH];

  logic             fifo_full, fifo_empty;
  logic             handshake, done_evt, bypass, push, pop, complete, spurious;
  logic [CNT_W-1:0] latency;

  assign busy        = (state_reg != st_idle);
  assign ap_continue = busy;
  assign finish      = (state_reg == st_fin);
  assign fifo_full   = (occ_reg == DEPTH_C);
  assign fifo_empty  = (occ_reg == '0);
  assign ap_start    = (state_reg == st_issue) && !fifo_full;

  // A done that coincides with a start into an empty FIFO completes that start directly.
  assign handshake = ap_start && ap_ready;
  assign done_evt  = busy && ap_done;
  assign bypass    = handshake && done_evt && fifo_empty;
  assign push      = handshake && !bypass;
  assign pop       = done_evt && !fifo_empty;
  assign complete  = pop || bypass;
  assign spurious  = done_evt && fifo_empty && !handshake;
  assign latency   = bypass ? '0 : (cycle_reg - ts_mem[rd_ptr_reg]);

  assign txn_issued   = txn_issued_reg;
  assign txn_done     = txn_done_reg;
  assign last_latency = last_lat_reg;
  assign max_latency  = max_lat_reg;
  assign total_cycles = total_reg;
  assign proto_err    = perr_reg;

  always_comb begin
    state_next      = state_reg;
    num_next        = num_reg;
    gap_next        = gap_reg;
    gap_cnt_next    = gap_cnt_reg;
    cycle_next      = cycle_reg;
    txn_issued_next = txn_issued_reg;
    txn_done_next   = txn_done_reg;
    last_lat_next   = last_lat_reg;
    max_lat_next    = max_lat_reg;
    total_next      = total_reg;
    perr_next       = perr_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    occ_next        = occ_reg;

    case (state_reg)
      st_idle: begin
        if (cfg_start) begin
          num_next        = cfg_num_txn;
          gap_next        = cfg_gap;
          cycle_next      = '0;
          txn_issued_next = '0;
          txn_done_next   = '0;
          last_lat_next   = '0;
          max_lat_next    = '0;
          total_next      = '0;
          perr_next       = 1'b0;
          if (cfg_num_txn == '0) begin
            state_next = st_fin;
          end else if (cfg_gap == 8'd0) begin
            state_next = st_issue;
          end else begin
            state_next   = st_gap;
            gap_cnt_next = cfg_gap;
          end
        end
      end
      st_issue: begin
        if (handshake) begin
          txn_issued_next = txn_issued_reg + 1'b1;
          if (txn_issued_reg + 1'b1 == num_reg) begin
            state_next = st_drain;
          end else if (gap_reg != 8'd0) begin
            state_next   = st_gap;
            gap_cnt_next = gap_reg;
          end
        end
      end
      st_gap: begin
        if (gap_cnt_reg == 8'd1) state_next = st_issue;
        else gap_cnt_next = gap_cnt_reg - 8'd1;
      end
      st_drain: begin
        if (txn_done_reg == num_reg) state_next = st_fin;
      end
      st_fin: begin
        state_next = st_idle;
        total_next = cycle_reg;
      end
      default: state_next = st_idle;
    endcase

    if (busy) cycle_next = cycle_reg + 1'b1;

    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase

    if (complete) begin
      last_lat_next = latency;
      if (latency > max_lat_reg) max_lat_next = latency;
      txn_done_next = txn_done_reg + 1'b1;
    end
    if (spurious) perr_next = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_reg      <= st_idle;
      num_reg        <= '0;
      gap_reg        <= '0;
      gap_cnt_reg    <= '0;
      cycle_reg      <= '0;
      txn_issued_reg <= '0;
      txn_done_reg   <= '0;
      last_lat_reg   <= '0;
      max_lat_reg    <= '0;
      total_reg      <= '0;
      perr_reg       <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      num_reg        <= num_next;
      gap_reg        <= gap_next;
      gap_cnt_reg    <= gap_cnt_next;
      cycle_reg      <= cycle_next;
      txn_issued_reg <= txn_issued_next;
      txn_done_reg   <= txn_done_next;
      last_lat_reg   <= last_lat_next;
      max_lat_reg    <= max_lat_next;
      total_reg      <= total_next;
      perr_reg       <= perr_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      occ_reg        <= occ_next;
    end
  end

  // Timestamp storage needs no reset: entries are only read after being written.
  always_ff @(posedge ap_clk) begin
    if (push) ts_mem[wr_ptr_reg] <= cycle_reg;
  end

endmodule

// File: tb/tb_ap_ctrl_txn_driver.sv
// Directed bench for ap_ctrl_txn_driver: a table of whole runs against a behavioural
// kernel, plus hand sequences for spurious done, cfg_start while busy and reset mid-run.
module tb_ap_ctrl_txn_driver;
  localparam int CNT_W = 32;
  localparam int TXN_W = 16;
  localparam int DEPTH = 4;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [TXN_W-1:0] cfg_num_txn = '0;
  logic [7:0]       cfg_gap = '0;
  logic             ap_ready = 1'b0;
  logic             ap_done;
  logic             kern_done = 1'b0;
  logic             spur_done = 1'b0;
  logic             ap_start, ap_continue, busy, finish, proto_err;
  logic [TXN_W-1:0] txn_issued, txn_done;
  logic [CNT_W-1:0] last_latency, max_latency, total_cycles;

  assign ap_done = kern_done | spur_done;

  always #5 ap_clk = ~ap_clk;

  ap_ctrl_txn_driver #(.CNT_W(CNT_W), .TXN_W(TXN_W), .OUTST_DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start),
    .cfg_num_txn(cfg_num_txn), .cfg_gap(cfg_gap), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .busy(busy), .finish(finish), .txn_issued(txn_issued), .txn_done(txn_done),
    .last_latency(last_latency), .max_latency(max_latency),
    .total_cycles(total_cycles), .proto_err(proto_err)
  );

  // Kernel model and run monitor; works on falling edges, the test drives 1 time unit later.
  int cyc = 0, run_base = 0, hs_n = 0, fin_n = 0, hs_first = 0, hs_last = 0;
  int max_occ = 0, occ = 0, kern_lat = 0, kern_step = 0;
  int kq[$];
  logic busy_d = 1'b0;

  initial begin
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        kq.delete();
        kern_done = 1'b0;
        busy_d = 1'b0;
      end else begin
        if (busy === 1'b1 && !busy_d) begin
          run_base = cyc - 1;
          hs_n = 0; fin_n = 0; hs_first = 0; hs_last = 0; max_occ = 0; occ = 0;
          kq.delete();
        end
        busy_d = (busy === 1'b1);
        if (ap_start === 1'b1 && ap_ready) begin
          kq.push_back(cyc + kern_lat - hs_n * kern_step);
          if (hs_n == 0) hs_first = cyc - run_base;
          hs_last = cyc - run_base;
          hs_n++;
          occ++;
          if (occ > max_occ) max_occ = occ;
        end
        kern_done = 1'b0;
        if (kq.size() > 0 && kq[0] == cyc) begin
          kern_done = 1'b1;
          void'(kq.pop_front());
          occ--;
        end
        if (finish === 1'b1) fin_n++;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge ap_clk);
      #1;
    end
  endtask

  // Leaves the caller one cycle after the accepting edge (first busy cycle).
  task automatic launch(input int num, input int gap);
    step(1);
    cfg_num_txn = TXN_W'(num);
    cfg_gap     = 8'(gap);
    cfg_start   = 1'b1;
    step(1);
    cfg_start   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  typedef struct {
    int num, gap, lat, step;
    int e_issued, e_done, e_last, e_max, e_total, e_hs_n, e_hs_first, e_hs_last, e_occ;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // num gap lat step | issued done last max total hs_n first last max_occ
    vecs[0] = '{3, 0,  5, 0,  3, 3,  5,  5,  9,  3, 1,  3, 3};  // back-to-back
    vecs[1] = '{2, 4,  2, 0,  2, 2,  2,  2, 13,  2, 5, 10, 1};  // gap run
    vecs[2] = '{8, 0, 20, 0,  8, 8, 20, 20, 46,  8, 1, 25, 4};  // outstanding limit
    vecs[3] = '{0, 3,  0, 0,  0, 0,  0,  0,  0,  0, 0,  0, 0};  // num=0
    vecs[4] = '{1, 0,  0, 0,  1, 1,  0,  0,  2,  1, 1,  1, 1};  // zero-latency bypass
    vecs[5] = '{3, 2,  3, 0,  3, 3,  3,  3, 13,  3, 3,  9, 2};  // push+pop same cycle
    vecs[6] = '{3, 2,  6, 2,  3, 3,  2,  6, 12,  3, 3,  9, 3};  // shrinking latency

    // Reset state
    step(3);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_continue", ap_continue, 0);
    chk("rst_finish", finish, 0);
    chk("rst_issued", txn_issued, 0);
    chk("rst_done", txn_done, 0);
    chk("rst_last", last_latency, 0);
    chk("rst_max", max_latency, 0);
    chk("rst_total", total_cycles, 0);
    chk("rst_perr", proto_err, 0);
    ap_rst_n = 1'b1;
    ap_ready = 1'b1;
    step(2);

    // ap_done while idle is ignored
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    step(1);
    chk("idle_done_perr", proto_err, 0);
    chk("idle_done_cnt", txn_done, 0);

    for (int i = 0; i < 7; i++) begin
      kern_lat  = vecs[i].lat;
      kern_step = vecs[i].step;
      launch(vecs[i].num, vecs[i].gap);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_issued", i), txn_issued, vecs[i].e_issued);
      chk($sformatf("v%0d_done", i), txn_done, vecs[i].e_done);
      chk($sformatf("v%0d_last", i), last_latency, vecs[i].e_last);
      chk($sformatf("v%0d_max", i), max_latency, vecs[i].e_max);
      chk($sformatf("v%0d_total", i), total_cycles, vecs[i].e_total);
      chk($sformatf("v%0d_hs_n", i), hs_n, vecs[i].e_hs_n);
      chk($sformatf("v%0d_hs_first", i), hs_first, vecs[i].e_hs_first);
      chk($sformatf("v%0d_hs_last", i), hs_last, vecs[i].e_hs_last);
      chk($sformatf("v%0d_max_occ", i), max_occ, vecs[i].e_occ);
      chk($sformatf("v%0d_fin_n", i), fin_n, 1);
      chk($sformatf("v%0d_perr", i), proto_err, 0);
      chk($sformatf("v%0d_start_low", i), ap_start, 0);
      $display("run %0d num=%0d gap=%0d issued=%0d done=%0d last=%0d max=%0d total=%0d",
               i, vecs[i].num, vecs[i].gap, txn_issued, txn_done, last_latency,
               max_latency, total_cycles);
    end

    // Spurious done with FIFO empty while busy: sticky until next accepted cfg_start
    kern_lat = 2;
    kern_step = 0;
    launch(1, 3);
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    chk("spur_perr_set", proto_err, 1);
    chk("spur_no_count", txn_done, 0);
    wait_idle("spur");
    chk("spur_perr_sticky", proto_err, 1);
    chk("spur_done", txn_done, 1);
    chk("spur_last", last_latency, 2);
    $display("run spur perr=%0d done=%0d last=%0d", proto_err, txn_done, last_latency);

    // cfg_start during a run is ignored
    kern_lat = 5;
    launch(2, 0);
    chk("busy_perr_clr", proto_err, 0);
    step(1);
    cfg_num_txn = 16'd7;
    cfg_gap     = 8'd1;
    cfg_start   = 1'b1;
    step(1);
    cfg_start   = 1'b0;
    wait_idle("busycfg");
    chk("busycfg_issued", txn_issued, 2);
    chk("busycfg_done", txn_done, 2);
    chk("busycfg_total", total_cycles, 8);
    chk("busycfg_fin_n", fin_n, 1);
    $display("run busycfg issued=%0d total=%0d", txn_issued, total_cycles);

    // Reset in ISSUE with two outstanding
    kern_lat = 10;
    launch(6, 0);
    step(2);
    chk("mid_issued", txn_issued, 2);
    chk("mid_start", ap_start, 1);
    chk("mid_continue", ap_continue, 1);
    ap_rst_n = 1'b0;
    step(1);
    chk("abort_start", ap_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_finish", finish, 0);
    chk("abort_issued", txn_issued, 0);
    chk("abort_done", txn_done, 0);
    chk("abort_total", total_cycles, 0);
    chk("abort_max", max_latency, 0);
    ap_rst_n = 1'b1;
    step(5);
    chk("abort_no_fin", fin_n, 0);
    chk("abort_idle", busy, 0);

    kern_lat = 5;
    launch(3, 0);
    wait_idle("post");
    chk("post_issued", txn_issued, 3);
    chk("post_done", txn_done, 3);
    chk("post_last", last_latency, 5);
    chk("post_max", max_latency, 5);
    chk("post_total", total_cycles, 9);
    chk("post_hs_last", hs_last, 3);
    chk("post_fin_n", fin_n, 1);
    chk("post_perr", proto_err, 0);
    $display("run post-reset issued=%0d done=%0d last=%0d", txn_issued, txn_done, last_latency);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_txn_driver.md
Name: ap_ctrl_txn_driver

Overview:
- Synthesizable initiator for the ap_ctrl_hs block-level handshake. It drives ap_start and ap_continue into an HLS kernel and runs a programmed number of transactions with a programmable idle gap between starts.
- It timestamps each accepted start and reports per-transaction and worst-case start-to-done latency, plus total run cycles.
- It is the driving end of the handshake that the simulation-only module/loop status monitors observe. It sits in the on-board bring-up harness between the config regs and the kernel.

Parameters:
- CNT_W, 32, width of the cycle counter and all latency outputs.
- TXN_W, 16, width of the transaction count.
- OUTST_DEPTH, 4, max outstanding (accepted, not done) transactions; timestamp FIFO depth, power of 2.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous reset, active-low.
- cfg_start  in  1  one-cycle pulse; launches a run when idle.
- cfg_num_txn  in  TXN_W  number of transactions; sampled on accepted cfg_start.
- cfg_gap  in  8  idle cycles between a handshake and the next ap_start; sampled with cfg_num_txn.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel; start accepted when ap_start&&ap_ready.
- ap_done  in  1  from kernel; one-cycle completion pulse.
- ap_continue  out  1  to kernel; tied high whenever busy.
- busy  out  1  run in progress.
- finish  out  1  one-cycle pulse at end of run.
- txn_issued  out  TXN_W  accepted starts this run.
- txn_done  out  TXN_W  done pulses counted this run.
- last_latency  out  CNT_W  latency of the most recent completed transaction.
- max_latency  out  CNT_W  maximum latency this run.
- total_cycles  out  CNT_W  cycles from cfg_start accept to finish.
- proto_err  out  1  sticky: ap_done seen with no outstanding transaction.

Behaviour:
- Reset (ap_rst_n=0 at clock edge): all outputs 0, FSM=IDLE, FIFO empty, cycle counter 0. Reset mid-run aborts immediately and drops ap_start the next cycle. No finish pulse on abort.
- FSM states: IDLE, ISSUE, GAP, DRAIN, FIN.
- IDLE: on cfg_start, latch cfg, clear counters/latencies/proto_err, cycle counter := 0, busy=1.
  - If cfg_num_txn=0, go to FIN.
  - Else if cfg_gap=0, go to ISSUE.
  - Else go to GAP, counting cfg_gap cycles.
- cfg_start while busy is ignored.
- ISSUE: ap_start=1 unless FIFO full; when full, ap_start=0 and the FSM stalls in ISSUE.
  - On handshake, push the current cycle counter and increment txn_issued.
  - If txn_issued+1 == num, go to DRAIN.
  - Else if gap=0, stay in ISSUE with ap_start held high (back-to-back).
  - Else go to GAP.
- GAP: ap_start=0 for exactly gap cycles, then ISSUE. The first ap_start rises gap+1 cycles after the cfg_start edge.
- DRAIN: ap_start=0; when txn_done == num, go to FIN.
- FIN: finish=1 for one cycle, total_cycles := counter, busy=0 next cycle, then IDLE.
- The cycle counter increments every busy cycle and wraps modulo 2^CNT_W. Latency = (done_cycle − timestamp) mod 2^CNT_W.
- ap_done is processed in any busy state, in order.
  - If FIFO non-empty: pop, last_latency := latency, max_latency := max(max, latency), txn_done++.
  - If empty and no same-cycle push: proto_err := 1; counts not changed.
- Same-cycle handshake and ap_done:
  - With FIFO empty, bypass: latency 0, FIFO stays empty.
  - Otherwise push and pop both happen; occupancy is unchanged.
- ap_done in IDLE is ignored and does not set proto_err.
- ap_continue = busy.
- Latency outputs are registered and valid the cycle after ap_done.
- Outputs hold their values after finish until the next accepted cfg_start.

Test Plan:
- Back-to-back run: num=3, gap=0; kernel ready same cycle as start, done 5 cycles after each handshake.
  - Required: ap_start high 3 consecutive cycles, last_latency=5, max_latency=5.
  - Required: txn_issued=txn_done=3, one finish pulse, proto_err=0.
- Gap run: num=2, gap=4, kernel ready immediately, done after 2.
  - Required: ap_start rises at cycles 5 and 10 after cfg_start, max_latency=2.
- Outstanding limit: num=8, gap=0, kernel ready always, first done after 20 cycles.
  - Required: exactly 4 handshakes, then ap_start low until the first done; FIFO never overflows; all 8 complete.
- Zero-latency bypass: handshake and ap_done in the same cycle with FIFO empty.
  - Required: last_latency=0, txn_done increments, proto_err=0.
- Edge cases:
  - Spurious ap_done while busy with FIFO empty → proto_err=1 stays set until the next cfg_start.
  - num=0 → finish the cycle after IDLE, ap_start never asserted.
  - cfg_start during a run → ignored.
- Reset mid-run: ap_rst_n low in ISSUE with 2 outstanding.
  - Required next cycle: ap_start=0, busy=0, counters 0, no finish pulse.
  - Required: a new run afterwards behaves per the back-to-back case.
